deselect_16: RTL

Serial-to-parallel collector; the receive-side counterpart of the 16-to-1 slot selector. It advances one slot on every toggle of the shared 0.25 s timebase `time_025`, using the same two-flop edge detection as the selector, so both ends stay in lockstep. On each advance it captures the current serial bit into the matching slot of a 16-bit buffer. After slot 15 it publishes the full word with a one-cycle `valid` strobe. It sits at the far end of the single-wire link and feeds the parallel word to the counter/UART logic.

---
 rtl/deselect_16.sv | 77 +++++++
 1 files changed

// File: rtl/deselect_16.sv
// Receive-side 16-slot serial-to-parallel collector. Steps one slot per time_025
// toggle, in lockstep with the transmitter, and publishes each completed word.
module deselect_16 (
    input  logic        reset,
    input  logic        clk_in,
    input  logic        time_025,
    input  logic        in,
    input  logic        sync,
    output logic [15:0] out,
    output logic        valid,
    output logic [3:0]  addr
);

    logic        q1_reg;
    logic        q2_reg;
    logic        step;
    logic [15:0] frame_reg;
    logic [15:0] frame_next;
    logic [15:0] out_reg;
    logic        valid_reg;
    logic [3:0]  addr_reg;
    logic [3:0]  addr_next;
    logic        publish;

    // Both edges of the timebase advance the slot, matching the transmitter.
    assign step = q1_reg ^ q2_reg;

    assign publish = step && !sync && (addr_reg == 4'd15);

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_slot
            if (gi == 0) begin : g_first
                // A sync either clears the slot or, with a step, starts the new frame here.
                assign frame_next[gi] = sync ? (step & in)
                                      : ((step && addr_reg == 4'd0) ? in : frame_reg[gi]);
            end else begin : g_rest
                assign frame_next[gi] = sync ? 1'b0
                                      : ((step && addr_reg == 4'(gi)) ? in : frame_reg[gi]);
            end
        end
    endgenerate

    always_comb begin
        addr_next = addr_reg;
        if (sync) begin
            addr_next = step ? 4'd1 : 4'd0;
        end else if (step) begin
            addr_next = addr_reg + 4'd1;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            q1_reg    <= 1'b0;
            q2_reg    <= 1'b0;
            frame_reg <= 16'h0000;
            out_reg   <= 16'h0000;
            valid_reg <= 1'b0;
            addr_reg  <= 4'd0;
        end else begin
            q1_reg    <= time_025;
            q2_reg    <= q1_reg;
            frame_reg <= frame_next;
            addr_reg  <= addr_next;
            valid_reg <= publish;
            if (publish) begin
                out_reg <= {in, frame_reg[14:0]};
            end
        end
    end

    assign out   = out_reg;
    assign valid = valid_reg;
    assign addr  = addr_reg;

endmodule
